// File: rtl/bk_pkg.sv
// bk_pkg: shared constants and FSM state type for the BK accumulator slice
package bk_pkg;
  localparam int WIDTH = 32;
  localparam int CARRY_W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  typedef enum logic {ACC, HOLD} state_t;
endpackage

// File: rtl/bk_adder_32bit.sv
// bk_adder_32bit: combinational 32-bit Brent-Kung parallel-prefix adder
module bk_adder_32bit
  import bk_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH-1:0] g, p, pp;
  // Up-sweep builds power-of-two group terms, down-sweep fills the remaining prefixes
  always_comb begin
    pp = a ^ b;
    g = a & b;
    p = pp;
    g[0] = g[0] | (p[0] & cin);
    for (int l = 0; l < 5; l++)
      for (int i = 0; i < WIDTH; i++)
        if ((i + 1) % (2 << l) == 0) begin
          g[i] = g[i] | (p[i] & g[i - (1 << l)]);
          p[i] = p[i] & p[i - (1 << l)];
        end
    for (int l = 3; l >= 0; l--)
      for (int i = 0; i < WIDTH; i++)
        if ((i + 1) % (2 << l) == (1 << l) && i >= (2 << l)) begin
          g[i] = g[i] | (p[i] & g[i - (1 << l)]);
          p[i] = p[i] & p[i - (1 << l)];
        end
    sum = pp ^ {g[WIDTH-2:0], cin};
    cout = g[WIDTH-1];
  end
endmodule

// File: rtl/bk_accum_32bit.sv
// bk_accum_32bit: framed streaming accumulator built on the Brent-Kung adder
module bk_accum_32bit
  import bk_pkg::*;
#(
  parameter int CARRY_W = CARRY_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic [CARRY_W-1:0] out_carries,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_sat
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, sum, out_sum_q, out_sum_d;
  logic [CARRY_W-1:0] carries_q, carries_d, carries_n, out_carries_q, out_carries_d;
  logic [CNT_W-1:0] count_q, count_d, count_n, out_count_q, out_count_d;
  logic sat_q, sat_d, sat_n, out_sat_q, out_sat_d, cout, accept, done;
  bk_adder_32bit u_add (.a(acc_q), .b(in_data), .cin(1'b0), .sum(sum), .cout(cout));
  // State register
  always_ff @(posedge clk)
    if (rst) state_q <= ACC;
    else state_q <= state_d;
  // Next state: a last beat enters HOLD, the output handshake returns to ACC
  always_comb begin
    state_d = (state_q == ACC) ? ((in_valid & in_last) ? HOLD : ACC) : (out_ready ? ACC : HOLD);
  end
  // Handshake outputs depend only on the registered state
  always_comb begin
    in_ready = state_q == ACC;
    out_valid = state_q == HOLD;
  end
  // Saturating counters and frame capture; the last beat publishes and clears in one edge
  always_comb begin
    accept = in_valid & in_ready;
    done = accept & in_last;
    carries_n = carries_q + CARRY_W'(cout & ~&carries_q);
    count_n = count_q + CNT_W'(~&count_q);
    sat_n = sat_q | (cout & &carries_q) | &count_q;
    acc_d = accept ? (in_last ? '0 : sum) : acc_q;
    carries_d = accept ? (in_last ? '0 : carries_n) : carries_q;
    count_d = accept ? (in_last ? '0 : count_n) : count_q;
    sat_d = accept ? (~in_last & sat_n) : sat_q;
    out_sum_d = done ? sum : out_sum_q;
    out_carries_d = done ? carries_n : out_carries_q;
    out_count_d = done ? count_n : out_count_q;
    out_sat_d = done ? sat_n : out_sat_q;
  end
  // Datapath registers
  always_ff @(posedge clk)
    if (rst) begin
      acc_q <= '0;
      carries_q <= '0;
      count_q <= '0;
      sat_q <= 1'b0;
      out_sum_q <= '0;
      out_carries_q <= '0;
      out_count_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      carries_q <= carries_d;
      count_q <= count_d;
      sat_q <= sat_d;
      out_sum_q <= out_sum_d;
      out_carries_q <= out_carries_d;
      out_count_q <= out_count_d;
      out_sat_q <= out_sat_d;
    end
  assign out_sum = out_sum_q;
  assign out_carries = out_carries_q;
  assign out_count = out_count_q;
  assign out_sat = out_sat_q;
endmodule

// File: tb/tb_bk_accum_32bit.sv
// tb_bk_accum_32bit: model-checked directed test of the framed accumulator
module tb_bk_accum_32bit;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 1;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid, out_sat;
  logic [31:0] out_sum;
  logic [7:0] out_carries;
  logic [15:0] out_count;
  int vectors = 0, miscompares = 0;
  bit chk_en = 0;
  logic [63:0] m_total;
  int m_n;
  bit exp_valid = 0, exp_sat = 0;
  logic [31:0] exp_sum = 0;
  longint exp_car = 0, exp_cnt = 0;

  bk_accum_32bit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carries(out_carries), .out_count(out_count), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: exact arithmetic sum; wraps past 2^32 are the carry count
  always @(posedge clk) begin
    if (rst) begin
      m_total = 0; m_n = 0; exp_valid = 0;
      exp_sum = 0; exp_car = 0; exp_cnt = 0; exp_sat = 0;
    end else if (exp_valid) begin
      if (out_ready) exp_valid = 0;
    end else if (in_valid) begin
      m_total = m_total + {32'd0, in_data};
      m_n = m_n + 1;
      if (in_last) begin
        exp_valid = 1;
        exp_sum = m_total[31:0];
        exp_car = (m_total >> 32) > 255 ? 255 : longint'(m_total >> 32);
        exp_cnt = m_n > 65535 ? 65535 : m_n;
        exp_sat = (m_total >> 32) > 255 || m_n > 65535;
        m_total = 0; m_n = 0;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("out_valid", out_valid, exp_valid);
    chk("in_ready", in_ready, !exp_valid);
    if (exp_valid) begin
      chk("out_sum", out_sum, exp_sum);
      chk("out_carries", out_carries, exp_car);
      chk("out_count", out_count, exp_cnt);
      chk("out_sat", out_sat, exp_sat);
    end
  end

  task automatic send(input logic [31:0] d, input logic last);
    in_valid = 1; in_data = d; in_last = last;
    @(negedge clk);
    in_valid = 0; in_last = 0;
  endtask

  task automatic expect_res(input logic [31:0] s, input int c, input int n, input bit sat);
    chk("lit_valid", out_valid, 1);
    chk("lit_sum", out_sum, s);
    chk("lit_carries", out_carries, c);
    chk("lit_count", out_count, n);
    chk("lit_sat", out_sat, sat);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_sum", out_sum, 0);
    chk("rst_count", out_count, 0);
    chk_en = 1;
    @(negedge clk);
    send(56, 0); send(78, 1);
    expect_res(134, 0, 2, 0);
    @(negedge clk);
    send(567, 0); send(435, 0); send(1, 1);
    expect_res(1003, 0, 3, 0);
    chk("ready_low", in_ready, 0);
    @(negedge clk);
    chk("ready_back", in_ready, 1);
    send(32'd3794967295, 0); send(32'd500000001, 1);
    expect_res(0, 1, 2, 0);
    @(negedge clk);
    send(32'd3794967295, 0); send(32'd500000000, 1);
    expect_res(32'hFFFFFFFF, 0, 2, 0);
    @(negedge clk);
    out_ready = 0;
    send(10, 0); send(35, 1);
    in_valid = 1; in_data = 999;
    for (int i = 0; i < 5; i++) begin
      expect_res(45, 0, 2, 0);
      chk("bp_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    send(1, 0); send(2, 1);
    expect_res(3, 0, 2, 0);
    @(negedge clk);
    for (int i = 1; i <= 300; i++) send(32'hFFFFFFFF, i == 300);
    expect_res(32'd4294966996, 255, 300, 1);
    @(negedge clk);
    send(7, 1);
    expect_res(7, 0, 1, 0);
    @(negedge clk);
    send(23, 0); send(132, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_valid", out_valid, 0);
    send(3846, 0); send(9654, 1);
    expect_res(13500, 0, 2, 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
